// File: rtl/operand_pkg.sv
// Shared constants and types for the operand matrix streamer.
package operand_pkg;

    localparam int OP_MAX_DIM   = 4;
    localparam int OP_DIM_WIDTH = $clog2(OP_MAX_DIM + 1);
    localparam int ROW_STRIDE   = OP_MAX_DIM;

    localparam logic ORDER_ROW = 1'b0;
    localparam logic ORDER_COL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/operand_mat_streamer_if.sv
// Control, register-file read port and output stream of the operand streamer.
interface operand_mat_streamer_if
    import operand_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DIM_WIDTH  = OP_DIM_WIDTH
);

    logic                  start_i;
    logic [DIM_WIDTH-1:0]  dim_i;
    logic                  col_major_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_rd_data_i;
    // Output stream: a beat transfers on a rising clk edge where out_valid_o and
    // out_ready_i are both high; once raised, out_valid_o, out_data_o and
    // out_last_o hold steady until that transfer happens.
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  out_last_o;
    state_e                dbg_state;

    modport slave (
        input  start_i, dim_i, col_major_i, mem_rd_data_i, out_ready_i,
        output busy_o, done_o, mem_addr_o, out_data_o, out_valid_o, out_last_o,
        output dbg_state
    );

    modport master (
        output start_i, dim_i, col_major_i, mem_rd_data_i, out_ready_i,
        input  busy_o, done_o, mem_addr_o, out_data_o, out_valid_o, out_last_o,
        input  dbg_state
    );

endinterface

// File: rtl/operand_skid_fifo.sv
// Two-entry FIFO holding {last, data} beats between the register file and the stream.
module operand_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/operand_mat_streamer.sv
// Walks an N x N operand matrix in row- or column-major order and streams the
// elements out through a small FIFO that absorbs the one-cycle read latency.
module operand_mat_streamer
    import operand_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_DIM    = OP_MAX_DIM,
    parameter int DIM_WIDTH  = OP_DIM_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    operand_mat_streamer_if.slave bus
);

    state_e                state_q, state_d;
    logic [DIM_WIDTH-1:0]  n_q, o_q, i_q, n_last, dim_sat;
    logic                  col_q;
    logic                  inflight_q, last_inflight_q;
    logic [ADDR_WIDTH-1:0] cur_addr, addr_q;
    logic                  issue, issue_last, pop, out_valid, drained;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;

    assign dim_sat = (bus.dim_i > DIM_WIDTH'(MAX_DIM)) ? DIM_WIDTH'(MAX_DIM) : bus.dim_i;
    assign n_last  = n_q - DIM_WIDTH'(1);

    assign cur_addr = (col_q == ORDER_COL)
        ? ADDR_WIDTH'(i_q) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(o_q)
        : ADDR_WIDTH'(o_q) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(i_q);

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & bus.out_ready_i;

    // Only issue a read if the FIFO will still have room when its data lands.
    assign issue = (state_q == RUN) &&
                   (({1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
    assign issue_last = issue && (o_q == n_last) && (i_q == n_last);

    // Looks ahead through this cycle's pop so done follows the last handshake directly.
    assign drained = !inflight_q && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = (dim_sat == '0) ? DONE : RUN;
            RUN:     if (issue_last)  state_d = DRAIN;
            DRAIN:   if (drained)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_q             <= '0;
            o_q             <= '0;
            i_q             <= '0;
            col_q           <= ORDER_ROW;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            addr_q          <= '0;
        end else begin
            inflight_q      <= issue;
            last_inflight_q <= issue_last;
            if (state_q == IDLE && bus.start_i) begin
                n_q   <= dim_sat;
                col_q <= bus.col_major_i;
                o_q   <= '0;
                i_q   <= '0;
            end else if (issue) begin
                addr_q <= cur_addr;
                if (i_q == n_last) begin
                    i_q <= '0;
                    o_q <= o_q + DIM_WIDTH'(1);
                end else begin
                    i_q <= i_q + DIM_WIDTH'(1);
                end
            end
        end
    end

    operand_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .wdata_i ({last_inflight_q, bus.mem_rd_data_i}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    assign bus.mem_addr_o  = issue ? cur_addr : addr_q;
    assign bus.out_data_o  = fifo_head[DATA_WIDTH-1:0];
    assign bus.out_valid_o = out_valid;
    assign bus.out_last_o  = fifo_head[DATA_WIDTH] & out_valid;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_operand_mat_streamer.sv
// Bench for operand_mat_streamer: behavioural matrix walk model feeding a scoreboard,
// with a decoupled monitor on the output stream.
module tb_operand_mat_streamer;
    import operand_pkg::*;

    localparam int DW        = 32;
    localparam int AW        = 5;
    localparam int MD        = 4;
    localparam int DIMW      = 3;
    localparam int MEM_DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_mat_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DIMW)) bus ();

    operand_mat_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_DIM    (MD),
        .DIM_WIDTH  (DIMW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Register file with a registered read port.
    logic [DW-1:0] mem [MEM_DEPTH];
    always @(posedge clk) bus.mem_rd_data_i <= mem[bus.mem_addr_o];

    // ---------------- scoreboard state ----------------
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          beats_seen = 0;
    logic [DW:0] exp_q[$];
    int          ready_mode = 0;
    int          stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the sequence of {last, element} an N x N walk must produce.
    task automatic load_expected(input int dim, input bit col);
        int n;
        int addr;
        n = (dim > MD) ? MD : dim;
        for (int o = 0; o < n; o++) begin
            for (int i = 0; i < n; i++) begin
                addr = col ? (i * MD + o) : (o * MD + i);
                exp_q.push_back({(o == n - 1) && (i == n - 1), mem[addr]});
            end
        end
    endtask

    task automatic preload_pattern();
        for (int a = 0; a < MEM_DEPTH; a++) begin
            if (a < MD * MD) mem[a] = 32'(16 * (a / MD) + (a % MD));
            else             mem[a] = 32'hBAD0_0000 + 32'(a);
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.out_ready_i = 1'b0;
                stall_left--;
            end else if (ready_mode == 1) begin
                bus.out_ready_i = 1'($urandom_range(0, 1));
            end else begin
                bus.out_ready_i = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_beat  = '0;
    logic [DW:0] exp_beat;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 64'(bus.out_valid_o), 64'd1);
                check("stall_beat_held", 64'({bus.out_last_o, bus.out_data_o}), 64'(prev_beat));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat",
                             {bus.out_last_o, bus.out_data_o});
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", 64'({bus.out_last_o, bus.out_data_o}), 64'(exp_beat));
                end
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_beat  = {bus.out_last_o, bus.out_data_o};
        end
    end

    // ---------------- driver tasks ----------------
    // Returns #1 after the edge that samples start (cycle index 0).
    task automatic start_run(input int dim, input bit col);
        load_expected(dim, col);
        @(posedge clk);
        #1;
        bus.dim_i       = DIMW'(dim);
        bus.col_major_i = col;
        bus.start_i     = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check("busy_after_start", 64'(bus.busy_o), 64'd1);
    endtask

    task automatic finish_run(input int c_now, input int exp_done, input string tag);
        int c;
        c = c_now;
        while (bus.done_o !== 1'b1 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (bus.done_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no done after %0d cycles, expected done", tag, c);
            exp_q.delete();
        end else begin
            if (exp_done >= 0) check({tag, "_done_cycle"}, 64'(c), 64'(exp_done));
            check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
            check({tag, "_busy_drop"}, 64'(bus.busy_o), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_done"}, 64'(bus.done_o), 64'd0);
        check({tag, "_addr"}, 64'(bus.mem_addr_o), 64'd0);
        check({tag, "_valid"}, 64'(bus.out_valid_o), 64'd0);
        check({tag, "_data"}, 64'(bus.out_data_o), 64'd0);
        check({tag, "_last"}, 64'(bus.out_last_o), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int b0;
        int guard;
        bus.start_i     = 1'b0;
        bus.dim_i       = '0;
        bus.col_major_i = 1'b0;
        preload_pattern();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_state", 64'(bus.dbg_state), 64'(IDLE));
        rst = 1'b0;

        // Row-major N=4 with latency checks
        start_run(4, 1'b0);
        @(posedge clk);
        #1;
        check("latency_c1_valid", 64'(bus.out_valid_o), 64'd0);
        @(posedge clk);
        #1;
        check("latency_c2_valid", 64'(bus.out_valid_o), 64'd1);
        check("latency_c2_data", 64'(bus.out_data_o), 64'h00);
        finish_run(2, 18, "row4");

        // Column-major N=4
        start_run(4, 1'b1);
        finish_run(0, 18, "col4");

        // Row-major N=3
        start_run(3, 1'b0);
        finish_run(0, 11, "row3");

        // Random back-pressure plus a 10-cycle stall
        ready_mode = 1;
        start_run(4, 1'b0);
        repeat (6) @(posedge clk);
        stall_left = 10;
        finish_run(0, -1, "stall4");
        ready_mode = 0;
        repeat (12) @(posedge clk);

        // N=0: no beats, immediate done
        b0 = beats_seen;
        start_run(0, 1'b0);
        finish_run(0, 0, "n0");
        check("n0_no_beats", 64'(beats_seen - b0), 64'd0);

        // N=7 saturates to 4
        start_run(7, 1'b1);
        finish_run(0, 18, "n7");

        // Reset in the middle of a run
        b0 = beats_seen;
        start_run(4, 1'b0);
        guard = 0;
        while (beats_seen < b0 + 5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_beat5", 64'(beats_seen - b0 >= 5), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 64'(bus.done_o), 64'd0);
        rst = 1'b0;
        start_run(4, 1'b0);
        finish_run(0, 18, "after_rst");

        // Randomised matrices, sizes, orders and back-pressure
        ready_mode = 1;
        for (int k = 0; k < 6; k++) begin
            for (int a = 0; a < MEM_DEPTH; a++) mem[a] = $urandom;
            start_run(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            finish_run(0, -1, "rand");
        end
        ready_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_mat_streamer.md
Name: operand_mat_streamer

Overview:
- Reader for the matrix operand register file: walks an N x N operand matrix (N <= MAX_DIM) stored row-major with stride MAX_DIM, and streams elements out on a valid/ready interface.
- Order is row-major or column-major (transpose on the fly).
- Sits between the operand register file read port and the matrix-multiply datapath.

Parameters:
- DATA_WIDTH, 32, element width
- ADDR_WIDTH, 5, register-file address width
- MAX_DIM, 4, maximum matrix dimension; element (r,c) lives at address r*MAX_DIM + c
- DIM_WIDTH, 3, width of dim_i (clog2(MAX_DIM+1))

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- dim_i  in  DIM_WIDTH  matrix dimension N; latched on start
- col_major_i  in  1  0 = row-major order, 1 = column-major; latched on start
- busy_o  out  1  high from the start edge until the done pulse, inclusive
- done_o  out  1  one-cycle pulse after the last beat handshake
- mem_addr_o  out  ADDR_WIDTH  read address to the register file
- mem_rd_data_i  in  DATA_WIDTH  register-file read data, valid one cycle after the address (registered read, no enable)
- out_data_o  out  DATA_WIDTH  streamed element
- out_valid_o  out  1  element valid
- out_ready_i  in  1  consumer ready
- out_last_o  out  1  high with the final element of the matrix

Behaviour:
- Interface decided: single clock clk_i; rst_i is asynchronous, active-high.
- Reset values: busy_o=0, done_o=0, mem_addr_o=0, out_valid_o=0, out_data_o=0, out_last_o=0. FSM returns to IDLE, counters clear, FIFO and in-flight tracking flush.
- Reset mid-stream aborts immediately. No done_o is produced for the aborted run.
- FSM states:
  - IDLE: start_i=1 latches dim/order and goes to RUN. If N==0, goes to DONE instead. N > MAX_DIM saturates to MAX_DIM.
  - RUN: issues addresses. After issuing address N*N-1, goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and nothing is in flight, then goes to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- Address generation:
  - Outer counter o and inner counter i, each 0..N-1.
  - Row-major: addr = o*MAX_DIM + i. Column-major: addr = i*MAX_DIM + o.
  - i wraps at N-1 and increments o.
  - The multiply by MAX_DIM is a constant shift/multiply, computed at ADDR_WIDTH.
- Read latency:
  - An address issued in cycle k returns data in cycle k+1, which is pushed into the FIFO at the end of k+1.
  - An in-flight flag tracks the outstanding read.
  - mem_addr_o holds its last value when not issuing; extra reads are harmless.
- Flow control:
  - 2-entry FIFO buffers the output.
  - Issue is allowed when (fifo_count + inflight - pop) < 2, where pop = out_valid_o & out_ready_i.
  - This sustains 1 beat/cycle with out_ready_i held high. No element is dropped or duplicated under any ready pattern.
- Output:
  - out_data_o/out_valid_o come from the FIFO head.
  - out_valid_o/out_data_o must remain stable while out_ready_i=0.
  - out_last_o travels as a FIFO sideband bit, set on the entry for the final issued address.
- Latency: start sampled at edge E0 → first out_valid_o after edge E2 (2 cycles). For N=4 with ready always high, the last beat is on the 17th cycle after E0.
- Completion: done_o pulses the cycle after the last beat's handshake enters DONE; busy_o drops the cycle after done_o.
- N==0: no beats, no memory reads of consequence; done_o pulses one cycle after start.

Decomposition:
- Shared package (operand_pkg):
  - MAX_DIM, DIM_WIDTH, ROW_STRIDE=MAX_DIM constants.
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - Order encoding constants ORDER_ROW=0, ORDER_COL=1.
- One natural sub-module: operand_skid_fifo, a 2-deep FIFO of {last, data} with push/pop/count.

Test Plan:
- Preload mem[r*4+c]=16r+c, N=4, row-major, ready=1 → 16 consecutive beats 0x00..0x33 in row order; last on 0x33; done_o pulse; first beat 2 cycles after start.
- Same preload, col_major=1 → addresses 0,4,8,12,1,5,...,15; data 0x00,0x10,0x20,0x30,0x01,...; last on 0x33.
- N=3 row-major → 9 beats from addresses 0,1,2,4,5,6,8,9,10; addresses 3,7,11+ never delivered.
- N=4, out_ready_i random 50% plus a 10-cycle stall → exact 16-beat sequence, no loss or duplication; data and valid stable during stalls.
- N=0 → zero beats, done_o one cycle after start; N=7 → behaves as N=4 (16 beats).
- rst_i asserted after beat 5 of 16 → all outputs 0 immediately; a new start afterwards delivers a full clean 16-beat sequence.
